// File: rtl/temp_sensor_freq_counter.sv
// Ring-oscillator temperature sensor readout: counts rising edges of the
// asynchronous sensor oscillator over a window of 2^(gate_sel+8) clk cycles
// and holds the saturated result, plus a byte-muxed view for the pad ring.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start
// ARM    | clear edge counter / ovf-pending, load gate timer with N-1
// COUNT  | N cycles of edge counting, gate timer counting down to 0
// DONE   | result visible (valid pulse); re-arm if continuous, else IDLE
module temp_sensor_freq_counter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             osc_in,
  input  logic             start,
  input  logic             continuous,
  input  logic [2:0]       gate_sel,
  input  logic             byte_sel,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             busy,
  output logic             ovf,
  output logic [7:0]       data_byte
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_COUNT,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   osc_edge;

  logic [CNT_W-1:0]       edge_cnt_q;
  logic [CNT_W-1:0]       edge_cnt_d;
  logic                   ovf_pend_q;
  logic                   ovf_pend_d;

  logic [14:0]            timer_q;
  logic [15:0]            gate_n;
  logic [14:0]            gate_load;

  logic [CNT_W-1:0]       count_q;
  logic                   valid_q;
  logic                   busy_q;
  logic                   ovf_q;
  logic [15:0]            count_ext;

  // Synchronize the oscillator and keep one extra flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign osc_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Gate length N = 256 << gate_sel; the timer is loaded with N-1 so that
  // COUNT lasts exactly N cycles (timer values N-1 down to 0).
  assign gate_n    = 16'd256 << gate_sel;
  assign gate_load = 15'(gate_n - 16'd1);

  // Saturating edge counter next value; ovf-pending flags a lost edge.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    ovf_pend_d = ovf_pend_q;
    if (osc_edge) begin
      if (&edge_cnt_q) begin
        ovf_pend_d = 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + CNT_W'(1);
      end
    end
  end

  // Measurement sequencer with registered outputs. The result registers are
  // loaded on the last COUNT cycle so they are visible during DONE, which
  // keeps an edge in that last cycle inside the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      edge_cnt_q <= '0;
      ovf_pend_q <= 1'b0;
      timer_q    <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_ARM;
            busy_q  <= 1'b1;
          end
        end
        S_ARM: begin
          edge_cnt_q <= '0;
          ovf_pend_q <= 1'b0;
          timer_q    <= gate_load;
          state_q    <= S_COUNT;
        end
        S_COUNT: begin
          edge_cnt_q <= edge_cnt_d;
          ovf_pend_q <= ovf_pend_d;
          if (timer_q == 15'd0) begin
            count_q <= edge_cnt_d;
            ovf_q   <= ovf_pend_d;
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            timer_q <= timer_q - 15'd1;
          end
        end
        S_DONE: begin
          if (continuous) begin
            state_q <= S_ARM;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign count_ext = 16'(count_q);
  assign data_byte = byte_sel ? count_ext[15:8] : count_ext[7:0];

  assign count = count_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign ovf   = ovf_q;

endmodule
